pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Consumer side of the hazard request path: turns load-use hazard, EX-stage branch-taken and data-memory
//  wait requests into the per-stage write-enable/flush controls of the 5-stage RV32E pipeline.
//  Sits beside the hazard detector; drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Owns the multi-cycle memory-wait FSM with timeout, and stall/bubble performance counters.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles spent in MEM_WAIT before abort (>=2)
//  CNT_W        16  width of saturating performance counters
// PORTS
//  clk_i             in   1      core clock
//  rst_i             in   1      asynchronous, active-high reset
//  hazard_i          in   1      load-use hazard from hazard detector (ID vs EX)
//  branch_taken_i    in   1      branch/jump resolved taken in EX
//  mem_req_i         in   1      MEM stage holds a load/store this cycle
//  mem_ack_i         in   1      data memory completes the access this cycle
//  pc_write_o        out  1      PC register enable
//  if_id_write_o     out  1      IF/ID register enable
//  if_id_flush_o     out  1      IF/ID loads NOP
//  id_ex_flush_o     out  1      ID/EX loads bubble (control bits zero)
//  ex_mem_write_o    out  1      EX/MEM register enable
//  mem_wb_bubble_o   out  1      MEM/WB loads bubble
//  mem_err_o         out  1      one-cycle pulse: memory access timed out
//  stall_cnt_o       out  CNT_W  cycles frozen by memory wait (saturating)
//  bubble_cnt_o      out  CNT_W  load-use bubbles inserted (saturating)
// BEHAVIOUR
//  - FSM states RUN, MEM_WAIT. Reset: state RUN, wait counter 0, mem_err_o 0, both perf counters 0.
//  - While rst_i high: pc_write_o=if_id_write_o=ex_mem_write_o=0, if_id_flush_o=id_ex_flush_o=mem_wb_bubble_o=1.
//  - freeze = mem_req_i & ~mem_ack_i (RUN) | ~mem_ack_i (MEM_WAIT); combinational, same cycle.
//  - Priority (highest first), outputs combinational from state + inputs, zero added latency:
//    1 freeze: pc/if_id/ex_mem writes 0, mem_wb_bubble_o 1, no flushes; branch/hazard ignored this cycle.
//    2 branch_taken_i: all writes 1, if_id_flush_o=1, id_ex_flush_o=1 (squashes load-use victim too).
//    3 hazard_i: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1, ex_mem_write_o=1.
//    4 none: all writes 1, all flush/bubble 0.
//  - RUN -> MEM_WAIT when mem_req_i & ~mem_ack_i; wait counter loads 1.
//  - MEM_WAIT: mem_ack_i -> RUN (freeze released in the ack cycle, counter cleared);
//    else counter increments; when counter == MEM_TIMEOUT-1 and no ack: mem_err_o=1 next cycle,
//    state -> RUN, freeze released that cycle (MEM/WB gets bubble, access abandoned).
//  - Ack and timeout same cycle: ack wins, no error.
//  - stall_cnt_o +1 each freeze cycle; bubble_cnt_o +1 each cycle rule 3 applies; both saturate at all-ones.
//  - Async reset mid-MEM_WAIT: immediate return to RUN, counters cleared, no mem_err_o pulse.
// STRUCTURE
//  - Shared package: FSM state encoding (RUN=0, MEM_WAIT=1), default MEM_TIMEOUT, CNT_W constants.
//  - One sub-module: sat_counter (width param, inc, async clear) instantiated twice for perf counters.
//  - Wait counter width $clog2(MEM_TIMEOUT)+1; FSM and priority mux stay in top.
// TESTING
//  - Reset: rst_i=1 -> writes 0, flushes 1, counters 0; release -> idle outputs all writes 1, flushes 0.
//  - hazard_i=1 one cycle -> pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1; bubble_cnt_o=1 next cycle.
//  - hazard_i=1 & branch_taken_i=1 -> if_id_flush_o=1, id_ex_flush_o=1, pc_write_o=1; bubble_cnt_o unchanged.
//  - mem_req_i=1, ack after 3 cycles -> freeze 3 cycles, release in ack cycle, stall_cnt_o=3, mem_err_o 0.
//  - mem_req_i=1, no ack, MEM_TIMEOUT=4 -> freeze 4 cycles, mem_err_o pulse 1 cycle, state RUN.
//  - CNT_W=4, 20 hazard cycles -> bubble_cnt_o holds 15; rst_i in MEM_WAIT -> RUN, no mem_err_o.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// Holds the memory-wait FSM encoding and the default parameter values.
package pipeline_stall_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } stall_state_t;

  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int DEF_CNT_W       = 16;

  // Wait-counter width; the extra bit leaves headroom above MEM_TIMEOUT-1.
  function automatic int wait_cnt_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous clear, used for the performance counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Converts load-use, branch-taken and memory-wait requests into per-stage
// write-enable/flush controls for the 5-stage pipeline.
//
// state    | meaning
// RUN      | pipeline flowing; a pending memory access freezes it and enters MEM_WAIT
// MEM_WAIT | frozen on an outstanding data access until ack or timeout
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hazard_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_bubble_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam int WC_W = wait_cnt_width(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  stall_state_t    state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            freeze;
  logic            timeout;
  logic            bubble_inc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // The cycle after a timeout still sees the abandoned request; it must not re-freeze.
  always_comb begin
    freeze = 1'b0;
    case (state_q)
      RUN:      freeze = mem_req_i & ~mem_ack_i & ~mem_err_q;
      MEM_WAIT: freeze = ~mem_ack_i;
    endcase
  end

  assign timeout = (state_q == MEM_WAIT) & ~mem_ack_i & (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (timeout) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    pc_write_o      = 1'b1;
    if_id_write_o   = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_write_o  = 1'b1;
    mem_wb_bubble_o = mem_err_q;
    bubble_inc      = 1'b0;
    if (rst_i) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      if_id_flush_o   = 1'b1;
      id_ex_flush_o   = 1'b1;
      ex_mem_write_o  = 1'b0;
      mem_wb_bubble_o = 1'b1;
    end else if (freeze) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      ex_mem_write_o  = 1'b0;
      mem_wb_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (hazard_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
      bubble_inc    = 1'b1;
    end
  end

  assign mem_err_o = mem_err_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (freeze),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (bubble_inc),
    .count_o (bubble_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scoreboard bench for pipeline_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_stall_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       hazard_i = 1'b0;
  logic       branch_taken_i = 1'b0;
  logic       mem_req_i = 1'b0;
  logic       mem_ack_i = 1'b0;
  logic       pc_write_o, if_id_write_o, if_id_flush_o, id_ex_flush_o;
  logic       ex_mem_write_o, mem_wb_bubble_o, mem_err_o;
  logic [3:0] stall_cnt_o, bubble_cnt_o;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .hazard_i        (hazard_i),
    .branch_taken_i  (branch_taken_i),
    .mem_req_i       (mem_req_i),
    .mem_ack_i       (mem_ack_i),
    .pc_write_o      (pc_write_o),
    .if_id_write_o   (if_id_write_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .ex_mem_write_o  (ex_mem_write_o),
    .mem_wb_bubble_o (mem_wb_bubble_o),
    .mem_err_o       (mem_err_o),
    .stall_cnt_o     (stall_cnt_o),
    .bubble_cnt_o    (bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Control vector order: pc_write if_id_write if_id_flush id_ex_flush ex_mem_write mem_wb_bubble mem_err
  localparam logic [6:0] C_RST  = 7'b0011010;
  localparam logic [6:0] C_IDLE = 7'b1100100;
  localparam logic [6:0] C_HAZ  = 7'b0001100;
  localparam logic [6:0] C_BR   = 7'b1111100;
  localparam logic [6:0] C_FRZ  = 7'b0000010;
  localparam logic [6:0] C_ERR  = 7'b1100111;

  // Input vector order: rst hazard branch req ack
  localparam logic [4:0] I_RST  = 5'b10000;
  localparam logic [4:0] I_IDLE = 5'b00000;
  localparam logic [4:0] I_HAZ  = 5'b01000;
  localparam logic [4:0] I_HB   = 5'b01100;
  localparam logic [4:0] I_REQ  = 5'b00010;
  localparam logic [4:0] I_REQH = 5'b01010;
  localparam logic [4:0] I_ACK  = 5'b00011;

  typedef struct packed {
    logic [6:0] ctl;
    logic [3:0] st;
    logic [3:0] bu;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  task automatic step(input logic [4:0] in, input logic [6:0] ctl, input int st, input int bu);
    exp_t e;
    {rst_i, hazard_i, branch_taken_i, mem_req_i, mem_ack_i} = in;
    e.ctl = ctl;
    e.st  = 4'(st);
    e.bu  = 4'(bu);
    q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = q.pop_front();
      act = {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_flush_o,
             ex_mem_write_o, mem_wb_bubble_o, mem_err_o};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl vec%0d: got %b expected %b", vec_no, act, e.ctl);
      end
      checks++;
      if (stall_cnt_o !== e.st) begin
        errors++;
        $display("FAIL stall_cnt vec%0d: got %0d expected %0d", vec_no, stall_cnt_o, e.st);
      end
      checks++;
      if (bubble_cnt_o !== e.bu) begin
        errors++;
        $display("FAIL bubble_cnt vec%0d: got %0d expected %0d", vec_no, bubble_cnt_o, e.bu);
      end
      vec_no++;
    end
  end

  initial begin
    @(posedge clk_i);
    #1;
    // reset and basic priority
    step(I_RST,  C_RST,  0, 0);
    step(5'b11000, C_RST, 0, 0);
    step(I_IDLE, C_IDLE, 0, 0);
    step(I_HAZ,  C_HAZ,  0, 0);
    step(I_IDLE, C_IDLE, 0, 1);
    step(I_HB,   C_BR,   0, 1);
    step(I_IDLE, C_IDLE, 0, 1);
    // memory wait released by ack, hazard ignored while frozen
    step(I_REQ,  C_FRZ,  0, 1);
    step(I_REQH, C_FRZ,  1, 1);
    step(I_ACK,  C_IDLE, 2, 1);
    step(I_IDLE, C_IDLE, 2, 1);
    // timeout: four frozen cycles then a one-cycle error with bubble
    step(I_REQ,  C_FRZ,  2, 1);
    step(I_REQ,  C_FRZ,  3, 1);
    step(I_REQ,  C_FRZ,  4, 1);
    step(I_REQ,  C_FRZ,  5, 1);
    step(I_REQ,  C_ERR,  6, 1);
    step(I_IDLE, C_IDLE, 6, 1);
    // ack on the timeout cycle wins
    step(I_REQ,  C_FRZ,  6, 1);
    step(I_REQ,  C_FRZ,  7, 1);
    step(I_REQ,  C_FRZ,  8, 1);
    step(I_ACK,  C_IDLE, 9, 1);
    step(I_IDLE, C_IDLE, 9, 1);
    // reset in the middle of a wait
    step(I_REQ,  C_FRZ,  9, 1);
    step(I_REQ,  C_FRZ, 10, 1);
    step(5'b10010, C_RST, 0, 0);
    step(I_IDLE, C_IDLE, 0, 0);
    step(I_IDLE, C_IDLE, 0, 0);
    // bubble counter saturation
    for (int k = 0; k < 20; k++) step(I_HAZ, C_HAZ, 0, (k > 15) ? 15 : k);
    step(I_IDLE, C_IDLE, 0, 15);
    step(I_IDLE, C_IDLE, 0, 15);

    for (int t = 0; t < 10 && q.size() != 0; t++) @(posedge clk_i);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
